alu_share_arbiter: RTL

- Shares the single 8-bit combinational ALU between two requesters (e.g. execute unit and address/debug unit).
- Accepts operation requests over valid/ready handshakes and arbitrates round-robin.
- Drives the ALU's operand and function-select inputs from registers, captures the result byte, multiply high byte and 4-bit status, and returns them on one tagged response channel.

---
 rtl/alu_share_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one combinational ALU between two requesters.
// Each accepted op runs ACCEPT -> EXEC -> RESP and returns a tagged response with captured status.
module alu_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 9,
  parameter int MUL_OP  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_sel0,
  input  logic [3:0]       req_sel1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_mul_high,
  input  logic [3:0]       alu_sreg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_mul_high,
  output logic [3:0]       rsp_sreg,
  output logic             rsp_err,
  output logic [3:0]       sreg_last,
  output logic [15:0]      op_count
);

  localparam logic [4:0] NUM_OPS_L = 5'(NUM_OPS);
  localparam logic [3:0] MUL_SEL   = 4'(MUL_OP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             last_grant;
  logic             inflight_id;
  logic             inflight_err;
  logic             grant_id;
  logic             accept;
  logic [3:0]       win_sel;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             win_illegal;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every comb output gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = EXEC;
      EXEC:                   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: round-robin grant and request handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_id  = 1'b0;
    req_ready = 2'b00;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
    if ((state == IDLE) && !reset && (req_valid != 2'b00)) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Winner payload is sampled only on the accept edge, so later changes are harmless.
  assign win_sel     = grant_id ? req_sel1 : req_sel0;
  assign win_a       = grant_id ? req_a1   : req_a0;
  assign win_b       = grant_id ? req_b1   : req_b0;
  assign win_illegal = ({1'b0, win_sel} >= NUM_OPS_L);

  // ---------------------------------------------------------------------------
  // Datapath: ALU operand registers, response capture and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= 1'b1;
      inflight_id  <= 1'b0;
      inflight_err <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_mul_high <= '0;
      rsp_sreg     <= '0;
      rsp_err      <= 1'b0;
      sreg_last    <= '0;
      op_count     <= '0;
    end else begin
      if (accept) begin
        last_grant   <= grant_id;
        inflight_id  <= grant_id;
        inflight_err <= win_illegal;
        // Illegal codes run a harmless all-zero op; the result is discarded anyway.
        alu_sel      <= win_illegal ? 4'd0 : win_sel;
        alu_a        <= win_illegal ? '0   : win_a;
        alu_b        <= win_illegal ? '0   : win_b;
      end

      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= inflight_id;
        rsp_err   <= inflight_err;
        if (inflight_err) begin
          rsp_result   <= '0;
          rsp_mul_high <= '0;
          rsp_sreg     <= '0;
        end else begin
          rsp_result   <= alu_out;
          rsp_mul_high <= (alu_sel == MUL_SEL) ? alu_mul_high : '0;
          rsp_sreg     <= alu_sreg;
        end
      end

      if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
        if (!rsp_err) begin
          sreg_last <= rsp_sreg;
        end
      end
    end
  end

endmodule
